// File: rtl/lk_feature_sequencer_if.sv
// Stream and core-control bundle for the LK feature sequencer.
// The master modport is the sequencer; slave is the surrounding environment.
interface lk_feature_sequencer_if #(
   parameter int unsigned colbits      = 6,
   parameter int unsigned rowbits      = 5,
   parameter int unsigned d_limit_bits = 40
);
   logic                           in_valid;
   logic                           in_ready;
   logic [colbits-1:0]             in_x;
   logic [rowbits-1:0]             in_y;
   logic signed [31:0]             in_g11;
   logic signed [31:0]             in_g12;
   logic signed [31:0]             in_g22;

   logic                           core_start;
   logic [colbits-1:0]             core_x;
   logic [rowbits-1:0]             core_y;
   logic signed [31:0]             core_g11;
   logic signed [31:0]             core_g12;
   logic signed [31:0]             core_g22;
   logic                           core_valid_det;
   logic                           core_valid_d;
   logic                           core_stop;
   logic                           core_feature_loss;
   logic signed [d_limit_bits-1:0] core_dx;
   logic signed [d_limit_bits-1:0] core_dy;

   logic                           out_valid;
   logic                           out_ready;
   logic [colbits-1:0]             out_x;
   logic [rowbits-1:0]             out_y;
   logic signed [d_limit_bits-1:0] out_dx;
   logic signed [d_limit_bits-1:0] out_dy;
   logic [1:0]                     out_status;
   logic [15:0]                    feat_count;

   modport master (
      input  in_valid, in_x, in_y, in_g11, in_g12, in_g22,
      output in_ready,
      output core_start, core_x, core_y, core_g11, core_g12, core_g22,
      input  core_valid_det, core_valid_d, core_stop, core_feature_loss, core_dx, core_dy,
      output out_valid, out_x, out_y, out_dx, out_dy, out_status, feat_count,
      input  out_ready
   );

   modport slave (
      output in_valid, in_x, in_y, in_g11, in_g12, in_g22,
      input  in_ready,
      input  core_start, core_x, core_y, core_g11, core_g12, core_g22,
      output core_valid_det, core_valid_d, core_stop, core_feature_loss, core_dx, core_dy,
      input  out_valid, out_x, out_y, out_dx, out_dy, out_status, feat_count,
      output out_ready
   );
endinterface

// File: rtl/lk_feature_sequencer.sv
// Per-feature front-end for the pyramidal-LK refinement core: accepts a feature, checks det(G),
// launches the core, accumulates saturating dx/dy and emits one tagged result per feature.
module lk_feature_sequencer #(
   parameter int unsigned d_limit_bits       = 40,
   parameter int unsigned timeout_cycles     = 4096,
   parameter int unsigned tobits             = 13,
   parameter logic [15:0] feat_count_rst_val = 16'd0
) (
   input logic                    clk,
   input logic                    reset,
   lk_feature_sequencer_if.master bus
);

   typedef enum logic [2:0] {StIdle, StCheck, StStart, StRun, StResult} state_e;

   localparam logic [1:0] StatusOk       = 2'b00;
   localparam logic [1:0] StatusLoss     = 2'b01;
   localparam logic [1:0] StatusSingular = 2'b10;
   localparam logic [1:0] StatusTimeout  = 2'b11;

   localparam logic [tobits-1:0] TimerLast = tobits'(timeout_cycles - 1);

   state_e                         state_q;
   logic [tobits-1:0]              timer_q;
   logic signed [d_limit_bits-1:0] acc_dx_q, acc_dy_q;
   logic signed [d_limit_bits-1:0] next_dx, next_dy;
   logic                           run_exit;

   // Clamp to the signed range instead of wrapping on overflow.
   function automatic logic signed [d_limit_bits-1:0] sat_add(
      input logic signed [d_limit_bits-1:0] a,
      input logic signed [d_limit_bits-1:0] b
   );
      logic signed [d_limit_bits:0] sum;
      sum = {a[d_limit_bits-1], a} + {b[d_limit_bits-1], b};
      if (sum[d_limit_bits] != sum[d_limit_bits-1]) begin
         if (sum[d_limit_bits]) return {1'b1, {(d_limit_bits-1){1'b0}}};
         else                   return {1'b0, {(d_limit_bits-1){1'b1}}};
      end
      return sum[d_limit_bits-1:0];
   endfunction

   always_comb begin
      next_dx = acc_dx_q;
      next_dy = acc_dy_q;
      if (bus.core_valid_d) begin
         next_dx = sat_add(acc_dx_q, bus.core_dx);
         next_dy = sat_add(acc_dy_q, bus.core_dy);
      end
   end

   assign run_exit     = bus.core_feature_loss | bus.core_stop | (timer_q == TimerLast);
   assign bus.in_ready = (state_q == StIdle) & ~reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         timer_q        <= '0;
         acc_dx_q       <= '0;
         acc_dy_q       <= '0;
         bus.core_start <= 1'b0;
         bus.core_x     <= '0;
         bus.core_y     <= '0;
         bus.core_g11   <= '0;
         bus.core_g12   <= '0;
         bus.core_g22   <= '0;
         bus.out_valid  <= 1'b0;
         bus.out_x      <= '0;
         bus.out_y      <= '0;
         bus.out_dx     <= '0;
         bus.out_dy     <= '0;
         bus.out_status <= StatusOk;
         bus.feat_count <= feat_count_rst_val;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  bus.core_x   <= bus.in_x;
                  bus.core_y   <= bus.in_y;
                  bus.core_g11 <= bus.in_g11;
                  bus.core_g12 <= bus.in_g12;
                  bus.core_g22 <= bus.in_g22;
                  state_q      <= StCheck;
               end
            end
            StCheck: begin
               if (bus.core_valid_det) begin
                  bus.core_start <= 1'b1;
                  state_q        <= StStart;
               end else begin
                  // Singular G: report without ever launching the core.
                  bus.out_valid  <= 1'b1;
                  bus.out_x      <= bus.core_x;
                  bus.out_y      <= bus.core_y;
                  bus.out_dx     <= '0;
                  bus.out_dy     <= '0;
                  bus.out_status <= StatusSingular;
                  state_q        <= StResult;
               end
            end
            StStart: begin
               bus.core_start <= 1'b0;
               acc_dx_q       <= '0;
               acc_dy_q       <= '0;
               timer_q        <= '0;
               state_q        <= StRun;
            end
            StRun: begin
               timer_q  <= timer_q + tobits'(1);
               acc_dx_q <= next_dx;
               acc_dy_q <= next_dy;
               if (run_exit) begin
                  bus.out_valid <= 1'b1;
                  bus.out_x     <= bus.core_x;
                  bus.out_y     <= bus.core_y;
                  bus.out_dx    <= next_dx;
                  bus.out_dy    <= next_dy;
                  if (bus.core_feature_loss) bus.out_status <= StatusLoss;
                  else if (bus.core_stop)    bus.out_status <= StatusOk;
                  else                       bus.out_status <= StatusTimeout;
                  state_q <= StResult;
               end
            end
            StResult: begin
               if (bus.out_ready) begin
                  bus.out_valid  <= 1'b0;
                  bus.feat_count <= bus.feat_count + 16'd1;
                  state_q        <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_lk_feature_sequencer.sv
// Directed bench for lk_feature_sequencer; the core is modelled by per-cycle driven stimulus.
module tb_lk_feature_sequencer;
   localparam int unsigned CB = 6;
   localparam int unsigned RB = 5;
   localparam int unsigned DW = 40;

   localparam longint Q1   = longint'(1) << 36;
   localparam longint QMAX = (longint'(1) << 39) - 1;
   localparam longint QMIN = -(longint'(1) << 39);

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   lk_feature_sequencer_if #(.colbits(CB), .rowbits(RB), .d_limit_bits(DW)) ifc ();
   lk_feature_sequencer_if #(.colbits(CB), .rowbits(RB), .d_limit_bits(DW)) ifc2 ();

   lk_feature_sequencer #(.d_limit_bits(DW), .timeout_cycles(16), .tobits(13)) dut (
      .clk(clk), .reset(reset), .bus(ifc.master)
   );

   lk_feature_sequencer #(.d_limit_bits(DW), .timeout_cycles(16), .tobits(13),
                          .feat_count_rst_val(16'hFFFF)) dut_wrap (
      .clk(clk), .reset(reset), .bus(ifc2.master)
   );

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int s0;

   always @(posedge clk) if (ifc.core_start === 1'b1) start_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d required %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic send(input int x, input int y, input int g11, input int g12, input int g22,
                       input bit det);
      ifc.in_valid = 1'b1;
      ifc.in_x     = CB'(x);
      ifc.in_y     = RB'(y);
      ifc.in_g11   = 32'(g11);
      ifc.in_g12   = 32'(g12);
      ifc.in_g22   = 32'(g22);
      check("accept_ready", longint'(ifc.in_ready), 1);
      tick();
      ifc.in_valid       = 1'b0;
      ifc.core_valid_det = det;
      check("check_core_x", longint'(ifc.core_x), longint'(x));
      tick();
      ifc.core_valid_det = 1'b0;
   endtask

   task automatic run(input bit vd, input longint dx, input longint dy, input bit stop,
                      input bit loss);
      ifc.core_valid_d      = vd;
      ifc.core_dx           = DW'(dx);
      ifc.core_dy           = DW'(dy);
      ifc.core_stop         = stop;
      ifc.core_feature_loss = loss;
      tick();
      ifc.core_valid_d      = 1'b0;
      ifc.core_dx           = '0;
      ifc.core_dy           = '0;
      ifc.core_stop         = 1'b0;
      ifc.core_feature_loss = 1'b0;
   endtask

   task automatic take(input string tag, input int x, input int y, input longint dx,
                       input longint dy, input int st);
      check({tag, "_valid"}, longint'(ifc.out_valid), 1);
      check({tag, "_x"}, longint'(ifc.out_x), longint'(x));
      check({tag, "_y"}, longint'(ifc.out_y), longint'(y));
      check({tag, "_dx"}, longint'(ifc.out_dx), dx);
      check({tag, "_dy"}, longint'(ifc.out_dy), dy);
      check({tag, "_status"}, longint'(ifc.out_status), longint'(st));
      ifc.out_ready = 1'b1;
      tick();
      ifc.out_ready = 1'b0;
      check({tag, "_valid_drop"}, longint'(ifc.out_valid), 0);
      check({tag, "_ready_next"}, longint'(ifc.in_ready), 1);
   endtask

   initial begin
      ifc.in_valid = 0; ifc.in_x = '0; ifc.in_y = '0;
      ifc.in_g11 = '0; ifc.in_g12 = '0; ifc.in_g22 = '0;
      ifc.core_valid_det = 0; ifc.core_valid_d = 0; ifc.core_stop = 0;
      ifc.core_feature_loss = 0; ifc.core_dx = '0; ifc.core_dy = '0; ifc.out_ready = 0;
      ifc2.in_valid = 0; ifc2.in_x = '0; ifc2.in_y = '0;
      ifc2.in_g11 = '0; ifc2.in_g12 = '0; ifc2.in_g22 = '0;
      ifc2.core_valid_det = 0; ifc2.core_valid_d = 0; ifc2.core_stop = 0;
      ifc2.core_feature_loss = 0; ifc2.core_dx = '0; ifc2.core_dy = '0; ifc2.out_ready = 0;

      tick(); tick();
      check("rst_in_ready", longint'(ifc.in_ready), 0);
      check("rst_out_valid", longint'(ifc.out_valid), 0);
      check("rst_core_start", longint'(ifc.core_start), 0);
      check("rst_feat_count", longint'(ifc.feat_count), 0);
      check("rst_out_status", longint'(ifc.out_status), 0);
      reset = 1'b0;
      tick();
      check("idle_in_ready", longint'(ifc.in_ready), 1);

      // Reset during RUN discards the feature.
      send(5, 3, 1, 0, 1, 1);
      tick();
      run(1, Q1, Q1, 0, 0);
      reset = 1'b1;
      #1;
      check("midrst_in_ready", longint'(ifc.in_ready), 0);
      check("midrst_core_x", longint'(ifc.core_x), 0);
      check("midrst_core_g11", longint'(ifc.core_g11), 0);
      check("midrst_out_valid", longint'(ifc.out_valid), 0);
      check("midrst_feat_count", longint'(ifc.feat_count), 0);
      tick();
      reset = 1'b0;
      tick();

      // Normal path: 4 x (+0.25, -0.5) then stop.
      s0 = start_cnt;
      send(10, 7, 4 << 16, 0, 4 << 16, 1);
      check("norm_start_n2", longint'(ifc.core_start), 1);
      check("norm_core_g11", longint'(ifc.core_g11), longint'(4 << 16));
      check("norm_core_y", longint'(ifc.core_y), 7);
      tick();
      check("norm_start_drop", longint'(ifc.core_start), 0);
      repeat (3) run(1, Q1 / 4, -(Q1 / 2), 0, 0);
      run(1, Q1 / 4, -(Q1 / 2), 1, 0);
      check("norm_start_once", longint'(start_cnt - s0), 1);
      check("norm_count_before", longint'(ifc.feat_count), 0);
      take("norm", 10, 7, Q1, -2 * Q1, 0);
      check("norm_count_after", longint'(ifc.feat_count), 1);

      // Singular G: result at N+2, core never launched.
      s0 = start_cnt;
      send(1, 2, 1, 1, 1, 0);
      take("sing", 1, 2, 0, 0, 2);
      check("sing_no_start", longint'(start_cnt - s0), 0);

      // Loss wins over stop; final increment is included.
      send(3, 4, 1, 0, 1, 1);
      tick();
      run(1, Q1, 0, 0, 0);
      run(1, Q1, 0, 1, 1);
      take("loss", 3, 4, 2 * Q1, 0, 1);

      // Timeout at 16 RUN cycles: out_valid 17 cycles after START.
      send(6, 5, 1, 0, 1, 1);
      tick();
      repeat (15) run(0, 0, 0, 0, 0);
      check("tmo_not_yet", longint'(ifc.out_valid), 0);
      run(0, 0, 0, 0, 0);
      take("tmo", 6, 5, 0, 0, 3);

      // Saturation in both directions.
      send(8, 1, 1, 0, 1, 1);
      tick();
      repeat (3) run(1, QMAX, QMIN, 0, 0);
      run(0, 0, 0, 1, 0);
      take("sat", 8, 1, QMAX, QMIN, 0);
      check("count_after_sat", longint'(ifc.feat_count), 5);

      // Backpressure: result held stable while out_ready is low.
      send(7, 9, 1, 0, 1, 1);
      tick();
      run(1, Q1, -Q1, 1, 0);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", longint'(ifc.out_valid), 1);
         check("bp_dx", longint'(ifc.out_dx), Q1);
         check("bp_in_ready", longint'(ifc.in_ready), 0);
         tick();
      end
      take("bp", 7, 9, Q1, -Q1, 0);

      // Back-to-back features, results in order.
      for (int i = 0; i < 3; i++) begin
         send(20 + i, i, 1, 0, 1, 1);
         tick();
         run(1, longint'(i + 1), 0, 1, 0);
         take("b2b", 20 + i, i, longint'(i + 1), 0, 0);
      end
      check("b2b_count", longint'(ifc.feat_count), 9);

      // Counter wrap on the preloaded instance.
      check("wrap_pre", longint'(ifc2.feat_count), 65535);
      ifc2.in_valid = 1'b1;
      ifc2.in_x = 6'd2;
      tick();
      ifc2.in_valid = 1'b0;
      tick();
      check("wrap_valid", longint'(ifc2.out_valid), 1);
      check("wrap_status", longint'(ifc2.out_status), 2);
      ifc2.out_ready = 1'b1;
      tick();
      ifc2.out_ready = 1'b0;
      check("wrap_count", longint'(ifc2.feat_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lk_feature_sequencer.md
# lk_feature_sequencer

Front-end controller that drives the iterative pyramidal-LK refinement core, one feature point at a time. Accepts a feature (x, y, G-matrix entries) over a valid/ready stream, checks G invertibility, launches the core, and accumulates the core's per-iteration dx/dy increments. Waits for the stop, feature-loss or timeout condition, then emits one tagged result per feature on an output valid/ready stream. Sits between the feature-detector/structure-tensor stage and the flow-vector writer.

## Interface
- colbits, 6, x coordinate width
- rowbits, 5, y coordinate width
- d_limit_bits, 40, signed Q4.36 displacement width
- timeout_cycles, 4096, max RUN cycles per feature
- tobits, 13, timer width (must hold timeout_cycles)

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  feature available
- in_ready  out  1  sequencer can accept
- in_x / in_y  in  colbits / rowbits  feature coordinates
- in_g11, in_g12, in_g22  in  32 signed  G-matrix entries
- core_start  out  1  one-cycle launch pulse to core
- core_x / core_y  out  colbits / rowbits  held feature coordinates
- core_g11, core_g12, core_g22  out  32 signed  held G entries
- core_valid_det  in  1  core reports det(G) != 0 (combinational from core_g*)
- core_valid_d  in  1  core dx/dy valid this cycle
- core_stop  in  1  core reached iteration limit
- core_feature_loss  in  1  core lost the point
- core_dx, core_dy  in  d_limit_bits signed  per-iteration increment
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_x / out_y  out  colbits / rowbits  feature coordinates
- out_dx, out_dy  out  d_limit_bits signed  accumulated displacement
- out_status  out  2  00 ok, 01 loss, 10 singular, 11 timeout
- feat_count  out  16  results delivered, wraps at 2^16

## Operation
- States: IDLE, CHECK, START, RUN, RESULT.
- IDLE: in_ready = 1. On in_valid & in_ready, register x, y, g11/g12/g22 into hold regs (drive core_* continuously); go to CHECK.
- CHECK: sample core_valid_det. 0: status = 10, dx = dy = 0, go to RESULT without ever pulsing core_start. 1: go to START.
- START: core_start = 1 for exactly this cycle; clear accumulators and timer; go to RUN.
- RUN: each cycle timer += 1. On core_valid_d, acc_dx += core_dx, acc_dy += core_dy, saturating to signed max/min of d_limit_bits, never wrapping. Exit priority is feature_loss > stop > timeout:
  - core_feature_loss: status 01.
  - else core_stop: status 00.
  - else timer == timeout_cycles-1: status 11.
  - Any exit goes to RESULT.
- Increment arriving with core_valid_d in the exit cycle is included in the result.
- RESULT: out_valid = 1; out_* and status are held stable until out_valid & out_ready. On that handshake: feat_count += 1, go to IDLE.
- core_* outputs keep their last values outside RUN. Core signals are ignored outside RUN, except core_valid_det in CHECK.

## Timing
- Reset values: in_ready 0 (in_ready = IDLE & ~reset), core_start 0, core_x/y/g* 0, out_valid 0, out_x/y/dx/dy 0, out_status 00, feat_count 0; state IDLE, accumulators and timer 0.
- Accept at cycle N: CHECK at N+1, core_start at N+2, RUN from N+3.
- Singular path: out_valid at N+2.
- Exit condition seen in RUN cycle M: out_valid at M+1.
- Zero-wait downstream: RESULT lasts 1 cycle; next in_ready at M+2.
- One feature in flight; no input accepted outside IDLE.
- Reset mid-RUN or mid-RESULT: immediate return to reset values; the pending result is discarded and feat_count is not incremented.

## Test plan
- Normal path: G = (4.0, 0, 4.0) in Q format, core model gives 4 increments of dx = +0.25, dy = -0.5, then stop → out_dx = +1.0, out_dy = -2.0, status 00, core_start high exactly once at N+2, feat_count 0→1.
- Singular path: g11 = g22 = g12 = 1 with valid_det = 0 → out_valid at N+2, status 10, dx = dy = 0, core_start never asserted.
- Loss/stop priority: feature_loss and stop asserted in the same cycle as a final core_valid_d of dx = 1 → status 01, final increment included in out_dx.
- Timeout and saturation: core never stops, timeout_cycles = 16 → status 11, out_valid 17 cycles after START. Separately, repeated core_dx = max positive → out_dx saturates at 2^(d_limit_bits-1)-1.
- Backpressure and reset: out_ready held low 10 cycles → out_* stable, in_ready 0 throughout. Reset asserted during RUN → all outputs return to reset values, feat_count unchanged, next feature processed normally.
- Throughput and wrap: 3 back-to-back features with out_ready = 1 → results in order, feat_count = 3. Preload feat_count 0xFFFF → one result wraps it to 0.
